// File: rtl/pmp_csr_programmer.sv
// -----------------------------------------------------------------------------
// pmp_csr_programmer
//
// Programs one PMP entry per accepted command by issuing two CSR writes into
// simple_csr_regfile: first the full pmpcfg word that holds the entry's cfg
// byte, then the entry's pmpaddr. A shadow copy of every cfg byte is kept so
// that a single-byte update can be turned into a full-word pmpcfg write.
//
// Optional feature macro: PMP_PROG_LOCK_CHECK_EN
//   defined   -> commands that hit a locked entry (own L bit, or the next
//                entry locked in TOR mode) are rejected with rsp_err_o=1.
//   undefined -> only an out-of-range index is rejected.
//
// Parameters:
//   NR_ENTRIES  number of shadowed PMP entries (4, 8, 12 or 16)
//   PMP_LEN     width of a pmpaddr value (at most 32)
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_valid_i/ready_o   command handshake; transfer when both high at clk rise
//   req_idx_i             entry index
//   req_cfg_i             new cfg byte {L, 2'b0, A[1:0], X, W, R}
//   req_addr_i            new pmpaddr value
//   csr_wdata_o/addr_o    CSR write data / address to the regfile (registered)
//   csr_op_o              8'd31 = write, 8'd0 = no operation (registered)
//   rsp_valid_o           one-cycle completion pulse
//   rsp_err_o             command rejected; valid only with rsp_valid_o
//   busy_o                FSM not idle
//   dbg_state_o           current FSM state (0 IDLE, 1 CFG, 2 ADDR, 3 RESP)
//
// Handshake: a command transfers on the rising clk edge where req_valid_i and
// req_ready_o are both high. req_ready_o is high only in IDLE; a source must
// hold its command (valid and payload stable) until that transfer happens.
// -----------------------------------------------------------------------------
module pmp_csr_programmer #(
  parameter int NR_ENTRIES = 16,
  parameter int PMP_LEN    = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [3:0]         req_idx_i,
  input  logic [7:0]         req_cfg_i,
  input  logic [PMP_LEN-1:0] req_addr_i,
  output logic [31:0]        csr_wdata_o,
  output logic [11:0]        csr_addr_o,
  output logic [7:0]         csr_op_o,
  output logic               rsp_valid_o,
  output logic               rsp_err_o,
  output logic               busy_o,
  output logic [1:0]         dbg_state_o
);

  localparam logic [7:0] CSR_OP_WRITE = 8'd31;
  localparam logic [4:0] NR_ENTRIES_W = 5'(NR_ENTRIES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_ADDR = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             r_state;
  logic [3:0]         r_idx;
  logic [7:0]         r_cfg;
  logic [PMP_LEN-1:0] r_addr;
  // Sized for the largest legal configuration; entries at or above
  // NR_ENTRIES are never written because such commands are rejected.
  logic [7:0]         r_shadow [16];
  logic [31:0]        r_csr_wdata;
  logic [11:0]        r_csr_addr;
  logic [7:0]         r_csr_op;
  logic               r_rsp_valid;
  logic               r_rsp_err;

  logic               w_in_range;
  logic               w_reject;
  logic [31:0]        w_cfg_word;

  assign w_in_range = ({1'b0, req_idx_i} < NR_ENTRIES_W);

`ifdef PMP_PROG_LOCK_CHECK_EN
  logic [4:0] w_idx_p1;
  logic [3:0] w_nxt_idx;
  logic       w_own_lock;
  logic       w_tor_lock;

  assign w_idx_p1   = {1'b0, req_idx_i} + 5'd1;
  assign w_nxt_idx  = req_idx_i + 4'd1;
  assign w_own_lock = r_shadow[req_idx_i][7];
  // A locked TOR entry also freezes the pmpaddr of the entry below it, which
  // holds its lower bound. w_nxt_idx wraps for idx=15, but the range test
  // masks that case.
  assign w_tor_lock = (w_idx_p1 < NR_ENTRIES_W) && r_shadow[w_nxt_idx][7] &&
                      (r_shadow[w_nxt_idx][4:3] == 2'b01);
  assign w_reject   = !w_in_range || w_own_lock || w_tor_lock;
`else
  assign w_reject   = !w_in_range;
`endif

  // pmpcfg word for the requested entry: shadow bytes of its group of four,
  // with the addressed byte replaced by the incoming cfg byte.
  always_comb begin
    w_cfg_word = '0;
    for (int b = 0; b < 4; b++) begin
      if (2'(b) == req_idx_i[1:0]) begin
        w_cfg_word[8*b +: 8] = req_cfg_i;
      end else begin
        w_cfg_word[8*b +: 8] = r_shadow[{req_idx_i[3:2], 2'(b)}];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cfg       <= '0;
      r_addr      <= '0;
      r_csr_wdata <= '0;
      r_csr_addr  <= '0;
      r_csr_op    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          if (req_valid_i) begin
            r_idx  <= req_idx_i;
            r_cfg  <= req_cfg_i;
            r_addr <= req_addr_i;
            if (w_reject) begin
              // Rejected: no CSR traffic, straight to the response.
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state     <= S_CFG;
              r_csr_addr  <= {8'h3A, 2'b00, req_idx_i[3:2]};
              r_csr_wdata <= w_cfg_word;
              r_csr_op    <= CSR_OP_WRITE;
            end
          end
        end
        S_CFG: begin
          // The regfile takes the cfg word at this edge; commit the shadow.
          r_shadow[r_idx] <= r_cfg;
          r_state         <= S_ADDR;
          r_csr_addr      <= {8'h3B, r_idx};
          r_csr_wdata     <= 32'(r_addr);
          r_csr_op        <= CSR_OP_WRITE;
        end
        S_ADDR: begin
          r_state     <= S_RESP;
          r_csr_addr  <= '0;
          r_csr_wdata <= '0;
          r_csr_op    <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign dbg_state_o = r_state;
  assign csr_wdata_o = r_csr_wdata;
  assign csr_addr_o  = r_csr_addr;
  assign csr_op_o    = r_csr_op;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;

endmodule
